// File: rtl/gps_bb_pkg.sv
// Shared GPS baseband definitions: sample code width, 2-bit code to signed value mapping,
// and the unpacker state enum.
package gps_bb_pkg;

  localparam int unsigned BB_SAMPLE_BITS = 2;
  localparam int unsigned OUT_BITS       = 3;

  // Two's-complement values for the sign/magnitude codes 00, 01, 10, 11
  localparam logic [OUT_BITS-1:0] SMP_POS1 = 3'b001;
  localparam logic [OUT_BITS-1:0] SMP_POS3 = 3'b011;
  localparam logic [OUT_BITS-1:0] SMP_NEG1 = 3'b111;
  localparam logic [OUT_BITS-1:0] SMP_NEG3 = 3'b101;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } unpack_state_e;

  function automatic logic [OUT_BITS-1:0] map_sample(input logic [BB_SAMPLE_BITS-1:0] code);
    logic [OUT_BITS-1:0] val;
    case (code)
      2'b00:   val = SMP_POS1;
      2'b01:   val = SMP_POS3;
      2'b10:   val = SMP_NEG1;
      default: val = SMP_NEG3;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/bb_word_fifo.sv
// Word buffer between the file reader and the unpacker; a push into a full FIFO
// is dropped unless a pop happens in the same cycle.
module bb_word_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_pop  = pop && !empty_c;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bb_sample_unpacker.sv
// Unpacks packed 2-bit sign/magnitude baseband words into a valid/ready stream of
// signed 3-bit samples, MSB-first, with credit-based word requests upstream.
module bb_sample_unpacker
  import gps_bb_pkg::*;
#(
  parameter int unsigned IO_READWIDTH = 16,
  parameter int unsigned SAMPLE_BITS  = BB_SAMPLE_BITS,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    data_run,
  input  logic                    in_valid,
  input  logic [IO_READWIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_BITS-1:0]     out_sample,
  output logic [31:0]             sample_count,
  output logic                    overflow
);

  localparam int unsigned NUM_SAMPLES = IO_READWIDTH / SAMPLE_BITS;
  localparam int unsigned IDX_W       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  logic [IO_READWIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    pop_c;
  logic                    accept_c;
  logic                    run_q;

  unpack_state_e           state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IO_READWIDTH-1:0] word_q, word_d;
  logic [OUT_BITS-1:0]     sample_d;
  logic                    valid_d;

  bb_word_fifo #(
    .WIDTH (IO_READWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (pop_c),
    .data_in (in_data),
    .head_c  (fifo_head),
    .count   (fifo_count),
    .empty_c (fifo_empty)
  );

  // Outstanding requests count against free space; a pending pop earns no credit
  assign data_run = !reset && enable &&
                    ((32'(fifo_count) + 32'(run_q)) < FIFO_DEPTH);
  assign accept_c = out_valid && out_ready;

  // Word register is kept left-aligned so the current sample is always the top code
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    sample_d = out_sample;
    valid_d  = out_valid;
    pop_c    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop_c    = 1'b1;
          state_d  = ST_ACTIVE;
          idx_d    = '0;
          word_d   = fifo_head;
          sample_d = map_sample(fifo_head[IO_READWIDTH-1 -: BB_SAMPLE_BITS]);
          valid_d  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (accept_c) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              pop_c    = 1'b1;
              idx_d    = '0;
              word_d   = fifo_head;
              sample_d = map_sample(fifo_head[IO_READWIDTH-1 -: BB_SAMPLE_BITS]);
            end else begin
              state_d = ST_EMPTY;
              idx_d   = '0;
              valid_d = 1'b0;
            end
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            word_d   = word_q << SAMPLE_BITS;
            sample_d = map_sample(word_d[IO_READWIDTH-1 -: BB_SAMPLE_BITS]);
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      idx_q      <= '0;
      word_q     <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      out_sample <= sample_d;
      out_valid  <= valid_d;
    end
  end

  // Credit history, accepted-sample counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q        <= 1'b0;
      sample_count <= '0;
      overflow     <= 1'b0;
    end else begin
      run_q <= data_run;
      if (accept_c) begin
        sample_count <= sample_count + 32'd1;
      end
      if (in_valid && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bb_sample_unpacker.sv
// Scoreboard bench for bb_sample_unpacker: a driver answers word requests and queues the
// expected samples, a monitor compares every presented sample and the accepted-sample count.
module tb_bb_sample_unpacker;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NS    = W / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          data_run;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_sample;
  logic [31:0]   sample_count;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  int            exp_q[$];
  logic [W-1:0]  src_q[$];
  bit            force_mode = 1'b0;
  bit            sb_flush = 1'b0;
  bit            cnt_load = 1'b0;
  logic [31:0]   cnt_load_val = '0;
  logic [31:0]   acc_model = '0;
  int            seen = 0;

  bb_sample_unpacker #(
    .IO_READWIDTH (W),
    .SAMPLE_BITS  (2),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .data_run     (data_run),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sample   (out_sample),
    .sample_count (sample_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Sign bit chooses polarity, magnitude bit chooses 1 or 3
  function automatic int code_value(input logic [1:0] c);
    int mag;
    mag = c[0] ? 3 : 1;
    return c[1] ? -mag : mag;
  endfunction

  task automatic model_word(input logic [W-1:0] w);
    logic [1:0] c;
    for (int k = 0; k < int'(NS); k++) begin
      c = 2'(w >> (int'(W) - 2 - 2 * k));
      exp_q.push_back(code_value(c));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"},    32'(out_valid),  32'd0);
    check({tag, "_out_sample"},   32'(out_sample), 32'd0);
    check({tag, "_sample_count"}, sample_count,    32'd0);
    check({tag, "_overflow"},     32'(overflow),   32'd0);
    check({tag, "_data_run"},     32'(data_run),   32'd0);
  endtask

  task automatic wait_seen(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (seen < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, accepted %0d, needed %0d", name, seen, target);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0 || src_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, %0d samples and %0d words left", name, exp_q.size(), src_q.size());
    end
  endtask

  // Upstream reader: answers a request one cycle later, or streams blindly in force mode
  initial begin
    int            fsent;
    bit            req;
    logic [W-1:0]  w;
    in_valid = 1'b0;
    in_data  = '0;
    fsent    = 0;
    forever begin
      @(negedge clk);
      req = data_run;
      @(posedge clk);
      #2;
      if (!force_mode) fsent = 0;
      if (src_q.size() > 0 && (force_mode || req)) begin
        w        = src_q.pop_front();
        in_valid = 1'b1;
        in_data  = w;
        // With the sink stalled only FIFO_DEPTH buffered words plus the held word survive
        if (!force_mode || fsent < int'(DEPTH) + 1) model_word(w);
        if (force_mode) fsent++;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
    end
  end

  // Monitor: every presented sample must equal the queue head; count tracks accepts
  initial begin
    forever begin
      @(negedge clk);
      if (sb_flush) begin
        exp_q.delete();
        acc_model = '0;
      end else begin
        if (cnt_load) acc_model = cnt_load_val;
        else check("sample_count", sample_count, acc_model);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_sample: got out_valid=1 sample %0d, expected no sample", $signed(out_sample));
          end else begin
            check("sample", 32'($signed(out_sample)), 32'(exp_q[0]));
            if (out_ready) begin
              void'(exp_q.pop_front());
              acc_model = acc_model + 32'd1;
              seen++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    reset     = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check_reset_vals("reset");

    // Single known word
    cyc();
    reset     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    src_q.push_back(16'h1B1B);
    wait_drain(200, "single_word");
    cyc();
    @(negedge clk);
    check("single_word_count", sample_count, 32'd8);

    // Back-to-back words: no bubble at word boundaries
    cyc();
    for (int i = 0; i < 6; i++) src_q.push_back(W'($urandom));
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 48; i++) begin
      check("b2b_no_bubble", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    check("b2b_tail_idle", 32'(out_valid), 32'd0);
    check("b2b_overflow", 32'(overflow), 32'd0);

    // Backpressure mid-word, then random ready/enable
    cyc();
    base = seen;
    for (int i = 0; i < 10; i++) src_q.push_back(W'($urandom));
    wait_seen(base + 3, 300, "bp_start");
    cyc();
    out_ready = 1'b0;
    repeat (20) cyc();
    @(negedge clk);
    check("bp_data_run_low", 32'(data_run), 32'd0);
    check("bp_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 150; i++) begin
      cyc();
      out_ready = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 3) != 0);
      if (i % 16 == 0) src_q.push_back(W'($urandom));
    end
    cyc();
    enable    = 1'b1;
    out_ready = 1'b1;
    wait_drain(600, "random_drain");
    @(negedge clk);
    check("random_overflow", 32'(overflow), 32'd0);

    // Forced overflow: six blind words into a stalled sink
    cyc();
    out_ready = 1'b0;
    enable    = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(W'($urandom));
    force_mode = 1'b1;
    repeat (8) cyc();
    force_mode = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    cyc();
    out_ready = 1'b1;
    wait_drain(300, "ovf_drain");
    repeat (3) cyc();
    @(negedge clk);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-word after the third sample, then an all-ones word
    cyc();
    enable = 1'b1;
    base   = seen;
    src_q.push_back(W'($urandom));
    wait_seen(base + 3, 200, "rst_start");
    cyc();
    reset     = 1'b1;
    out_ready = 1'b0;
    cyc();
    sb_flush = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    cyc();
    sb_flush  = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    src_q.push_back(16'hFFFF);
    wait_drain(200, "rst_ffff");
    cyc();
    @(negedge clk);
    check("rst_ffff_count", sample_count, 32'd8);

    // Counter wrap from a preloaded value
    cyc();
    force dut.sample_count = 32'hFFFF_FFFE;
    cnt_load     = 1'b1;
    cnt_load_val = 32'hFFFF_FFFE;
    cyc();
    release dut.sample_count;
    cnt_load = 1'b0;
    base     = seen;
    src_q.push_back(W'($urandom));
    wait_seen(base + 3, 200, "wrap_start");
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    check("wrap_count", sample_count, 32'd1);
    cyc();
    out_ready = 1'b1;
    wait_drain(200, "wrap_drain");
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
